// File: rtl/mul_shift_add_pkg.sv
// Shared definitions for the shift-and-add multiplier.
// Holds the default operand width and the FSM state encoding.
package mul_shift_add_pkg;

  localparam int DEF_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_B = 2'd1,
    CALC   = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/mul_controller.sv
// Multiplier controller FSM (IDLE, LOAD_B, CALC, DONE).
// Ports: start and datapath flags in; load/calc enables, busy, done out.
module mul_controller
  import mul_shift_add_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic b_zero,
  input  logic q_next_zero,
  output logic load_a,
  output logic load_b,
  output logic calc,
  output logic busy,
  output logic done
);

  state_t state;
  state_t state_nx;

  always_ff @(posedge clock) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load_a   = 1'b0;
    load_b   = 1'b0;
    calc     = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load_a   = 1'b1;
          state_nx = LOAD_B;
        end
      end
      LOAD_B: begin
        load_b   = 1'b1;
        busy     = 1'b1;
        state_nx = b_zero ? DONE : CALC;
      end
      CALC: begin
        calc     = 1'b1;
        busy     = 1'b1;
        state_nx = q_next_zero ? DONE : CALC;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: rtl/mul_datapath.sv
// Multiplier datapath: M, Q, P, iteration counter, adder and shifters.
// Ports: enables from controller in; b_zero/q_next_zero flags, product, iter_count out.
module mul_datapath
  import mul_shift_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load_a,
  input  logic               load_b,
  input  logic               calc,
  input  logic [WIDTH-1:0]   data_in,
  output logic               b_zero,
  output logic               q_next_zero,
  output logic [2*WIDTH-1:0] product,
  output logic [CW-1:0]      iter_count
);

  logic [2*WIDTH-1:0] m;
  logic [2*WIDTH-1:0] p;
  logic [WIDTH-1:0]   q;
  logic [CW-1:0]      iter;

  always_ff @(posedge clock) begin
    if (reset) begin
      m    <= '0;
      p    <= '0;
      q    <= '0;
      iter <= '0;
    end else if (load_a) begin
      m    <= {{WIDTH{1'b0}}, data_in};
      p    <= '0;
      iter <= '0;
    end else if (load_b) begin
      q <= data_in;
    end else if (calc) begin
      if (q[0])
        p <= p + m;
      m    <= m << 1;
      q    <= q >> 1;
      iter <= iter + 1'b1;
    end
  end

  // Lets the controller stop as soon as no multiplier bits remain.
  assign q_next_zero = ((q >> 1) == '0);
  assign b_zero      = (data_in == '0);
  assign product     = p;
  assign iter_count  = iter;

endmodule

// File: rtl/mul_shift_add.sv
// Sequential unsigned shift-and-add multiplier, operands on shared data_in.
// Ports: clock, reset, start, data_in in; busy, done, product, iter_count out.
module mul_shift_add
  import mul_shift_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [WIDTH-1:0]         data_in,
  output logic                     busy,
  output logic                     done,
  output logic [2*WIDTH-1:0]       product,
  output logic [$clog2(WIDTH):0]   iter_count
);

  logic load_a;
  logic load_b;
  logic calc;
  logic b_zero;
  logic q_next_zero;

  mul_controller u_ctrl (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .b_zero      (b_zero),
    .q_next_zero (q_next_zero),
    .load_a      (load_a),
    .load_b      (load_b),
    .calc        (calc),
    .busy        (busy),
    .done        (done)
  );

  mul_datapath #(
    .WIDTH (WIDTH),
    .CW    ($clog2(WIDTH) + 1)
  ) u_dp (
    .clock       (clock),
    .reset       (reset),
    .load_a      (load_a),
    .load_b      (load_b),
    .calc        (calc),
    .data_in     (data_in),
    .b_zero      (b_zero),
    .q_next_zero (q_next_zero),
    .product     (product),
    .iter_count  (iter_count)
  );

endmodule

// File: tb/tb_mul_shift_add.sv
// Self-checking bench for mul_shift_add (WIDTH=16).
// Directed operations with a queue of expected results.
module tb_mul_shift_add;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] data_in = '0;
  logic        busy;
  logic        done;
  logic [31:0] product;
  logic [4:0]  iter_count;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] prod;
    logic [4:0]  iters;
    logic [5:0]  lat;
  } exp_t;

  exp_t sb[$];

  mul_shift_add #(.WIDTH(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .data_in    (data_in),
    .busy       (busy),
    .done       (done),
    .product    (product),
    .iter_count (iter_count)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int bitlen(input logic [15:0] b);
    int n = 0;
    for (int i = 0; i < 16; i++)
      if (b[i]) n = i + 1;
    return n;
  endfunction

  // Drives t0 (start, A) and t1 (B); returns at the start of t2.
  task automatic start_op(input logic [15:0] a,
                          input logic [15:0] b);
    exp_t e;
    int   n;
    n       = bitlen(b);
    e.prod  = {16'h0, a} * {16'h0, b};
    e.iters = 5'(n);
    e.lat   = 6'(2 + n);
    sb.push_back(e);
    start   = 1'b1;
    data_in = a;
    step();
    start   = 1'b0;
    data_in = b;
    chk("load_b_busy", {63'h0, busy}, 64'h1);
    chk("load_b_prod0", {32'h0, product}, 64'h0);
    step();
    data_in = '0;
  endtask

  // Waits for done; junk drives an ignored start during CALC/DONE.
  task automatic wait_done(input string tag, input bit junk);
    exp_t e;
    int   cyc;
    cyc = 2;
    while (!done && cyc < 40) begin
      if (junk) begin
        start   = 1'b1;
        data_in = 16'h1234;
      end
      step();
      cyc++;
    end
    e = sb.pop_front();
    chk({tag, "_done"}, {63'h0, done}, 64'h1);
    chk({tag, "_lat"}, 64'(cyc), 64'(e.lat));
    chk({tag, "_prod"}, {32'h0, product}, {32'h0, e.prod});
    chk({tag, "_iter"}, {59'h0, iter_count}, {59'h0, e.iters});
    chk({tag, "_busy"}, {63'h0, busy}, 64'h0);
    if (junk) begin
      start   = 1'b1;
      data_in = 16'h5555;
      step();
      start   = 1'b0;
      data_in = '0;
      chk({tag, "_ign_busy"}, {63'h0, busy}, 64'h0);
      chk({tag, "_ign_prod"}, {32'h0, product}, {32'h0, e.prod});
      step();
      chk({tag, "_hold"}, {32'h0, product}, {32'h0, e.prod});
    end
  endtask

  initial begin
    step();
    step();
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_done", {63'h0, done}, 64'h0);
    chk("rst_prod", {32'h0, product}, 64'h0);
    chk("rst_iter", {59'h0, iter_count}, 64'h0);
    reset = 1'b0;
    step();

    start_op(16'd5, 16'd3);
    wait_done("5x3", 1'b0);
    step();

    start_op(16'hFFFF, 16'hFFFF);
    wait_done("ffxff", 1'b0);
    step();

    start_op(16'd1234, 16'd0);
    wait_done("bzero", 1'b0);
    step();

    start_op(16'd0, 16'h00FF);
    wait_done("azero", 1'b0);
    step();

    start_op(16'd3, 16'h8000);
    wait_done("3x8000", 1'b1);

    // Reset at t5 of a long operation.
    start_op(16'hFFFF, 16'hFFFF);
    step();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    void'(sb.pop_front());
    chk("mid_rst_busy", {63'h0, busy}, 64'h0);
    chk("mid_rst_done", {63'h0, done}, 64'h0);
    chk("mid_rst_prod", {32'h0, product}, 64'h0);
    chk("mid_rst_iter", {59'h0, iter_count}, 64'h0);
    start_op(16'd7, 16'd6);
    wait_done("7x6", 1'b0);
    step();

    // Back-to-back: start in the cycle right after done.
    start_op(16'd2, 16'd2);
    wait_done("2x2", 1'b0);
    step();
    start_op(16'd9, 16'd9);
    wait_done("9x9", 1'b0);
    step();

    chk("sb_empty", 64'(sb.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
